tribuf_ctrl: RTL and testbench

Parametrised triple-buffer controller: the successor to the static-select muxes. It owns buffer-role rotation internally instead of taking an external select. A writer (A, capture side) and a reader (B, transmit side) each see one memory port. The block routes them, plus an idle dummy requester (D), onto three memory controllers X/Y/Z, and swaps roles on frame-completion pulses so the reader always gets the newest complete frame.

---
 rtl/tribuf_pkg.sv | 43 ++++
 rtl/tribuf_route.sv | 112 +++++++++++
 rtl/tribuf_ctrl.sv | 153 +++++++++++++++
 tb/tb_tribuf_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tribuf_pkg.sv
// Shared definitions for the triple-buffer controller.
// Holds the role-mapping select codes, buffer index encodings, the dummy
// requester constants and the helpers that map (writer, reader) indices to a
// select code and flag unreachable index pairs.
package tribuf_pkg;

  // Select codes: A (writer), B (reader), D (dummy) onto controllers X/Y/Z.
  localparam logic [2:0] SelAxByDz = 3'b000;
  localparam logic [2:0] SelAxBzDy = 3'b001;
  localparam logic [2:0] SelAyBxDz = 3'b010;
  localparam logic [2:0] SelAyBzDx = 3'b011;
  localparam logic [2:0] SelAzBxDy = 3'b100;
  localparam logic [2:0] SelAzByDx = 3'b101;

  // Buffer / controller indices.
  localparam logic [1:0] IdxX = 2'd0;
  localparam logic [1:0] IdxY = 2'd1;
  localparam logic [1:0] IdxZ = 2'd2;

  // The dummy requester never starts a transaction (start is active low).
  localparam logic DummyStart = 1'b1;
  localparam logic DummyRw    = 1'b0;

  function automatic logic [2:0] idx_to_select(input logic [1:0] w, input logic [1:0] r);
    logic [2:0] sel;
    sel = SelAxByDz;
    case ({w, r})
      {IdxX, IdxY}: sel = SelAxByDz;
      {IdxX, IdxZ}: sel = SelAxBzDy;
      {IdxY, IdxX}: sel = SelAyBxDz;
      {IdxY, IdxZ}: sel = SelAyBzDx;
      {IdxZ, IdxX}: sel = SelAzBxDy;
      {IdxZ, IdxY}: sel = SelAzByDx;
      default:      sel = SelAxByDz;
    endcase
    return sel;
  endfunction

  function automatic logic is_illegal(input logic [1:0] w, input logic [1:0] r);
    return (w == r) || (w == 2'd3) || (r == 2'd3);
  endfunction

endpackage

// File: rtl/tribuf_route.sv
// Combinational router for the triple-buffer controller.
// Ports: select (role code); A/B request buses in; X/Y/Z request buses out;
// X/Y/Z ready and read data in; ready_a/ready_b and data_t out.
module tribuf_route
  import tribuf_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic [2:0]        select,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              start_a,
  input  logic              rw_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              start_b,
  input  logic              rw_b,
  output logic [ADDR_W-1:0] addr_x,
  output logic [DATA_W-1:0] data_x,
  output logic              start_x,
  output logic              rw_x,
  output logic [ADDR_W-1:0] addr_y,
  output logic [DATA_W-1:0] data_y,
  output logic              start_y,
  output logic              rw_y,
  output logic [ADDR_W-1:0] addr_z,
  output logic [DATA_W-1:0] data_z,
  output logic              start_z,
  output logic              rw_z,
  input  logic [DATA_W-1:0] rdata_x,
  input  logic [DATA_W-1:0] rdata_y,
  input  logic [DATA_W-1:0] rdata_z,
  input  logic              ready_x,
  input  logic              ready_y,
  input  logic              ready_z,
  output logic              ready_a,
  output logic              ready_b,
  output logic [DATA_W-1:0] data_t
);

  logic [1:0] a_idx, b_idx;

  // Unused codes fall back to the reset mapping.
  always_comb begin
    a_idx = IdxX;
    b_idx = IdxY;
    case (select)
      SelAxBzDy: begin a_idx = IdxX; b_idx = IdxZ; end
      SelAyBxDz: begin a_idx = IdxY; b_idx = IdxX; end
      SelAyBzDx: begin a_idx = IdxY; b_idx = IdxZ; end
      SelAzBxDy: begin a_idx = IdxZ; b_idx = IdxX; end
      SelAzByDx: begin a_idx = IdxZ; b_idx = IdxY; end
      default:   begin a_idx = IdxX; b_idx = IdxY; end
    endcase
  end

  logic [ADDR_W-1:0] addr_m  [3];
  logic [DATA_W-1:0] data_m  [3];
  logic              start_m [3];
  logic              rw_m    [3];

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      addr_m[k]  = '0;
      data_m[k]  = '0;
      start_m[k] = DummyStart;
      rw_m[k]    = DummyRw;
      if (a_idx == 2'(k)) begin
        addr_m[k]  = addr_a;
        data_m[k]  = data_a;
        start_m[k] = start_a;
        rw_m[k]    = rw_a;
      end else if (b_idx == 2'(k)) begin
        addr_m[k]  = addr_b;
        data_m[k]  = data_b;
        start_m[k] = start_b;
        rw_m[k]    = rw_b;
      end
    end
  end

  assign addr_x  = addr_m[0];
  assign data_x  = data_m[0];
  assign start_x = start_m[0];
  assign rw_x    = rw_m[0];
  assign addr_y  = addr_m[1];
  assign data_y  = data_m[1];
  assign start_y = start_m[1];
  assign rw_y    = rw_m[1];
  assign addr_z  = addr_m[2];
  assign data_z  = data_m[2];
  assign start_z = start_m[2];
  assign rw_z    = rw_m[2];

  always_comb begin
    case (a_idx)
      IdxY:    ready_a = ready_y;
      IdxZ:    ready_a = ready_z;
      default: ready_a = ready_x;
    endcase
  end

  always_comb begin
    case (b_idx)
      IdxX:    begin ready_b = ready_x; data_t = rdata_x; end
      IdxZ:    begin ready_b = ready_z; data_t = rdata_z; end
      default: begin ready_b = ready_y; data_t = rdata_y; end
    endcase
  end

endmodule

// File: rtl/tribuf_ctrl.sv
// Triple-buffer controller top.
// Rotates writer/reader/idle buffer roles on frame_done pulses so the reader
// always picks up the newest complete frame; routes the writer (A), reader (B)
// and an idle dummy onto controllers X/Y/Z through tribuf_route.
// Ports: clk, rst (async, active high); A and B request buses with
// frame_done_a/b pulses; X/Y/Z request/response buses; ready_a, ready_b,
// data_t; select (role code), fresh (idle buffer newer than reader's),
// dropped (saturating count of overwritten unread frames).
module tribuf_ctrl
  import tribuf_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              start_a,
  input  logic              rw_a,
  input  logic              frame_done_a,
  output logic              ready_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              start_b,
  input  logic              rw_b,
  input  logic              frame_done_b,
  output logic              ready_b,
  output logic [DATA_W-1:0] data_t,
  output logic [ADDR_W-1:0] addr_x,
  output logic [DATA_W-1:0] data_x,
  output logic              start_x,
  output logic              rw_x,
  output logic [ADDR_W-1:0] addr_y,
  output logic [DATA_W-1:0] data_y,
  output logic              start_y,
  output logic              rw_y,
  output logic [ADDR_W-1:0] addr_z,
  output logic [DATA_W-1:0] data_z,
  output logic              start_z,
  output logic              rw_z,
  input  logic [DATA_W-1:0] rdata_x,
  input  logic [DATA_W-1:0] rdata_y,
  input  logic [DATA_W-1:0] rdata_z,
  input  logic              ready_x,
  input  logic              ready_y,
  input  logic              ready_z,
  output logic [2:0]        select,
  output logic              fresh,
  output logic [CNT_W-1:0]  dropped
);

  logic [1:0]       w_idx_q, w_idx_d;
  logic [1:0]       r_idx_q, r_idx_d;
  logic [1:0]       i_idx;
  logic             fresh_q, fresh_d;
  logic [CNT_W-1:0] dropped_q, dropped_d;

  // Indices are a permutation of {0,1,2}, so the idle one is the remainder.
  assign i_idx = 2'd3 - w_idx_q - r_idx_q;

  always_comb begin
    w_idx_d   = w_idx_q;
    r_idx_d   = r_idx_q;
    fresh_d   = fresh_q;
    dropped_d = dropped_q;
    if (is_illegal(w_idx_q, r_idx_q)) begin
      w_idx_d = IdxX;
      r_idx_d = IdxY;
      fresh_d = 1'b0;
    end else begin
      case ({frame_done_a, frame_done_b})
        2'b10: begin
          w_idx_d = i_idx;
          fresh_d = 1'b1;
          // Idle buffer already held an unread frame: it is being overwritten.
          if (fresh_q && (dropped_q != '1)) begin
            dropped_d = dropped_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        2'b01: begin
          if (fresh_q) begin
            r_idx_d = i_idx;
            fresh_d = 1'b0;
          end
        end
        2'b11: begin
          // Just-completed frame goes straight to the reader.
          w_idx_d = i_idx;
          r_idx_d = w_idx_q;
          fresh_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_idx_q   <= IdxX;
      r_idx_q   <= IdxY;
      fresh_q   <= 1'b0;
      dropped_q <= '0;
    end else begin
      w_idx_q   <= w_idx_d;
      r_idx_q   <= r_idx_d;
      fresh_q   <= fresh_d;
      dropped_q <= dropped_d;
    end
  end

  assign select  = idx_to_select(w_idx_q, r_idx_q);
  assign fresh   = fresh_q;
  assign dropped = dropped_q;

  tribuf_route #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_route (
    .select  (select),
    .addr_a  (addr_a),
    .data_a  (data_a),
    .start_a (start_a),
    .rw_a    (rw_a),
    .addr_b  (addr_b),
    .data_b  (data_b),
    .start_b (start_b),
    .rw_b    (rw_b),
    .addr_x  (addr_x),
    .data_x  (data_x),
    .start_x (start_x),
    .rw_x    (rw_x),
    .addr_y  (addr_y),
    .data_y  (data_y),
    .start_y (start_y),
    .rw_y    (rw_y),
    .addr_z  (addr_z),
    .data_z  (data_z),
    .start_z (start_z),
    .rw_z    (rw_z),
    .rdata_x (rdata_x),
    .rdata_y (rdata_y),
    .rdata_z (rdata_z),
    .ready_x (ready_x),
    .ready_y (ready_y),
    .ready_z (ready_z),
    .ready_a (ready_a),
    .ready_b (ready_b),
    .data_t  (data_t)
  );

endmodule

// File: tb/tb_tribuf_ctrl.sv
// Self-checking bench for tribuf_ctrl: a requester-position model compared
// every negedge, plus directed literal checks of the role-rotation rules.
module tb_tribuf_ctrl;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
  logic [DATA_W-1:0] data_a = '0, data_b = '0;
  logic start_a = 1'b1, start_b = 1'b1, rw_a = 1'b0, rw_b = 1'b0;
  logic frame_done_a = 1'b0, frame_done_b = 1'b0;
  logic ready_a, ready_b;
  logic [DATA_W-1:0] data_t;
  logic [ADDR_W-1:0] addr_x, addr_y, addr_z;
  logic [DATA_W-1:0] data_x, data_y, data_z;
  logic start_x, start_y, start_z, rw_x, rw_y, rw_z;
  logic [DATA_W-1:0] rdata_x = '0, rdata_y = '0, rdata_z = '0;
  logic ready_x = 1'b0, ready_y = 1'b0, ready_z = 1'b0;
  logic [2:0] select;
  logic fresh;
  logic [CNT_W-1:0] dropped;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  tribuf_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .addr_a(addr_a), .data_a(data_a), .start_a(start_a), .rw_a(rw_a),
    .frame_done_a(frame_done_a), .ready_a(ready_a),
    .addr_b(addr_b), .data_b(data_b), .start_b(start_b), .rw_b(rw_b),
    .frame_done_b(frame_done_b), .ready_b(ready_b), .data_t(data_t),
    .addr_x(addr_x), .data_x(data_x), .start_x(start_x), .rw_x(rw_x),
    .addr_y(addr_y), .data_y(data_y), .start_y(start_y), .rw_y(rw_y),
    .addr_z(addr_z), .data_z(data_z), .start_z(start_z), .rw_z(rw_z),
    .rdata_x(rdata_x), .rdata_y(rdata_y), .rdata_z(rdata_z),
    .ready_x(ready_x), .ready_y(ready_y), .ready_z(ready_z),
    .select(select), .fresh(fresh), .dropped(dropped)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: which controller (0=X,1=Y,2=Z) each requester currently holds.
  int pos_a, pos_b, pos_d;
  bit m_fresh;
  int m_drop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_a <= 0; pos_b <= 1; pos_d <= 2; m_fresh <= 1'b0; m_drop <= 0;
    end else if (frame_done_a && frame_done_b) begin
      pos_a <= pos_d; pos_b <= pos_a; pos_d <= pos_b; m_fresh <= 1'b0;
    end else if (frame_done_a) begin
      pos_a <= pos_d; pos_d <= pos_a; m_fresh <= 1'b1;
      if (m_fresh) m_drop <= (m_drop >= CNT_MAX) ? CNT_MAX : m_drop + 1;
    end else if (frame_done_b && m_fresh) begin
      pos_b <= pos_d; pos_d <= pos_b; m_fresh <= 1'b0;
    end
  end

  // Look the mapping up in the role-code table rather than computing it.
  function automatic logic [2:0] model_select(input int pa, input int pb);
    int ta [6] = '{0, 0, 1, 1, 2, 2};
    int tb [6] = '{1, 2, 0, 2, 0, 1};
    for (int c = 0; c < 6; c++) if (ta[c] == pa && tb[c] == pb) return 3'(c);
    return 3'b111;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [ADDR_W-1:0] ao [3];
      logic [DATA_W-1:0] dout [3];
      logic [DATA_W-1:0] rd [3];
      logic so [3], wo [3], rdy [3];
      ao   = '{addr_x, addr_y, addr_z};
      dout = '{data_x, data_y, data_z};
      so   = '{start_x, start_y, start_z};
      wo   = '{rw_x, rw_y, rw_z};
      rd   = '{rdata_x, rdata_y, rdata_z};
      rdy  = '{ready_x, ready_y, ready_z};
      chk("select", 32'(select), 32'(model_select(pos_a, pos_b)));
      chk("fresh", 32'(fresh), 32'(m_fresh));
      chk("dropped", 32'(dropped), 32'(m_drop));
      for (int k = 0; k < 3; k++) begin
        if (k == pos_a) begin
          chk("route_addr_a", 32'(ao[k]), 32'(addr_a));
          chk("route_data_a", 32'(dout[k]), 32'(data_a));
          chk("route_ctl_a", {so[k], wo[k]}, {start_a, rw_a});
        end else if (k == pos_b) begin
          chk("route_addr_b", 32'(ao[k]), 32'(addr_b));
          chk("route_data_b", 32'(dout[k]), 32'(data_b));
          chk("route_ctl_b", {so[k], wo[k]}, {start_b, rw_b});
        end else begin
          chk("route_dummy", {ao[k], dout[k]}, 32'h0);
          chk("route_ctl_d", {so[k], wo[k]}, 2'b10);
        end
      end
      chk("ready_a", 32'(ready_a), 32'(rdy[pos_a]));
      chk("ready_b", 32'(ready_b), 32'(rdy[pos_b]));
      chk("data_t", 32'(data_t), 32'(rd[pos_b]));
    end
  end

  task automatic rand_inputs();
    addr_a = 16'($urandom); data_a = 16'($urandom);
    addr_b = 16'($urandom); data_b = 16'($urandom);
    start_a = 1'($urandom); start_b = 1'($urandom);
    rw_a = 1'($urandom); rw_b = 1'($urandom);
    rdata_x = 16'($urandom); rdata_y = 16'($urandom); rdata_z = 16'($urandom);
    {ready_x, ready_y, ready_z} = 3'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      rand_inputs();
    end
  endtask

  // Pulse for one cycle; returns 2 time units after the edge that sampled it.
  task automatic pulse(input logic a, input logic b);
    @(posedge clk); #2;
    rand_inputs();
    frame_done_a = a; frame_done_b = b;
    @(posedge clk); #2;
    frame_done_a = 1'b0; frame_done_b = 1'b0;
    rand_inputs();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Reset state and reset routing.
    chk("rst_select", 32'(select), 32'h0);
    chk("rst_fresh", 32'(fresh), 32'h0);
    chk("rst_dropped", 32'(dropped), 32'h0);
    chk("rst_start_z", 32'(start_z), 32'h1);
    addr_a = 16'h1234; rdata_y = 16'hBEEF; #1;
    chk("rst_addr_x", 32'(addr_x), 32'h1234);
    chk("rst_data_t", 32'(data_t), 32'hBEEF);
    idle(3);

    // Writer completes: A takes Z, dummy takes X.
    pulse(1'b1, 1'b0);
    chk("a_select", 32'(select), 32'h5);
    chk("a_fresh", 32'(fresh), 32'h1);
    // Reader grabs the fresh frame: B takes X, Y becomes idle.
    pulse(1'b0, 1'b1);
    chk("ab_select", 32'(select), 32'h4);
    chk("ab_fresh", 32'(fresh), 32'h0);
    idle(2);

    // Reader done with nothing new: no change.
    do_reset();
    pulse(1'b0, 1'b1);
    chk("b_stale_select", 32'(select), 32'h0);
    chk("b_stale_dropped", 32'(dropped), 32'h0);
    rdata_y = 16'h5A5A; #1;
    chk("b_stale_data_t", 32'(data_t), 32'h5A5A);

    // Writer-only pulses: drops, then saturation.
    do_reset();
    repeat (3) pulse(1'b1, 1'b0);
    chk("a3_fresh", 32'(fresh), 32'h1);
    chk("a3_dropped", 32'(dropped), 32'h2);
    repeat (297) pulse(1'b1, 1'b0);
    chk("a300_dropped", 32'(dropped), 32'hFF);

    // Simultaneous pulses from reset: w=Z, r=X.
    do_reset();
    pulse(1'b1, 1'b1);
    chk("both_select", 32'(select), 32'h4);
    chk("both_fresh", 32'(fresh), 32'h0);
    chk("both_dropped", 32'(dropped), 32'h0);
    // Simultaneous pulses leave a nonzero drop count alone.
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    chk("pre_both_dropped", 32'(dropped), 32'h1);
    pulse(1'b1, 1'b1);
    chk("both2_dropped", 32'(dropped), 32'h1);
    chk("both2_fresh", 32'(fresh), 32'h0);

    // Walk to select=011 with fresh=1, then reset asynchronously mid-cycle.
    do_reset();
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    chk("pre_rst_select", 32'(select), 32'h3);
    chk("pre_rst_fresh", 32'(fresh), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_select", 32'(select), 32'h0);
    chk("async_rst_fresh", 32'(fresh), 32'h0);
    chk("async_rst_dropped", 32'(dropped), 32'h0);
    chk("async_rst_start_z", 32'(start_z), 32'h1);
    addr_a = 16'h0F0F; #1;
    chk("async_rst_addr_x", 32'(addr_x), 32'h0F0F);
    idle(2);
    rst = 1'b0;
    idle(4);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
